// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard/sequencing controller.
// The pipeline drives decode/execute status (master); the controller returns
// stall, bubble, flush and halt controls (slave).
interface hazard_ctrl_if;
   logic [3:0] i_idRdReg1;
   logic       i_idRdEn1;
   logic [3:0] i_idRdReg2;
   logic       i_idRdEn2;
   logic       i_exMemRd;
   logic [3:0] i_exWrReg;
   logic       i_exWrEn;
   logic       i_brTaken;
   logic       i_jmp;
   logic       i_hlt;

   logic       o_stallPC;
   logic       o_stallIFID;
   logic       o_bubbleIDEX;
   logic       o_flushIFID;
   logic       o_flushIDEX;
   logic       o_halted;
   logic [1:0] o_state;

   modport master (
      output i_idRdReg1, i_idRdEn1, i_idRdReg2, i_idRdEn2,
      output i_exMemRd, i_exWrReg, i_exWrEn,
      output i_brTaken, i_jmp, i_hlt,
      input  o_stallPC, o_stallIFID, o_bubbleIDEX,
      input  o_flushIFID, o_flushIDEX, o_halted, o_state
   );

   modport slave (
      input  i_idRdReg1, i_idRdEn1, i_idRdReg2, i_idRdEn2,
      input  i_exMemRd, i_exWrReg, i_exWrEn,
      input  i_brTaken, i_jmp, i_hlt,
      output o_stallPC, o_stallIFID, o_bubbleIDEX,
      output o_flushIFID, o_flushIDEX, o_halted, o_state
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 16-bit 5-stage CPU.
// Detects load-use hazards, applies branch/jump flushes and drains the
// pipeline on halt so the register file is fully written before o_halted.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   RUN     | normal flow; hazard, halt and jump decode are evaluated
//   LDSTALL | remaining load-use interlock cycles (PC and IF/ID held)
//   DRAIN   | halt decoded; fetch blocked while EX/MEM/WB empty out
//   HALTED  | pipeline drained, CPU stopped; only reset leaves
module hazard_ctrl #(
   parameter int LD_STALL_CYCLES = 1,
   parameter int DRAIN_CYCLES    = 3
) (
   input logic          i_clk,
   input logic          i_rst,
   hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      DRAIN   = 2'd2,
      HALTED  = 2'd3
   } state_t;

   // The hazard cycle in RUN counts as the first stall cycle, so LDSTALL
   // only covers the remainder.
   localparam logic [3:0] LdInit    = 4'(LD_STALL_CYCLES - 1);
   localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES);

   state_t     stateQ;
   state_t     stateNext;
   logic [3:0] stallCntQ;
   logic [3:0] stallCntNext;
   logic [3:0] drainCntQ;
   logic [3:0] drainCntNext;
   logic       haltedQ;

   logic       haz;
   logic       match1;
   logic       match2;
   logic       brFlush;

   // Load-use hazard: a load in EX targets a register ID is reading; r0 never hazards.
   always_comb begin
      match1 = bus.i_idRdEn1 & (bus.i_idRdReg1 == bus.i_exWrReg);
      match2 = bus.i_idRdEn2 & (bus.i_idRdReg2 == bus.i_exWrReg);
      haz    = bus.i_exMemRd & bus.i_exWrEn & (bus.i_exWrReg != 4'd0) & (match1 | match2);
   end

   // A taken branch overrides everything except reset and the HALTED state.
   always_comb begin
      brFlush = bus.i_brTaken & (stateQ != HALTED);
   end

   // State, counter and halted-flag registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stateQ    <= RUN;
         stallCntQ <= 4'd0;
         drainCntQ <= 4'd0;
         haltedQ   <= 1'b0;
      end else begin
         stateQ    <= stateNext;
         stallCntQ <= stallCntNext;
         drainCntQ <= drainCntNext;
         haltedQ   <= (stateNext == HALTED);
      end
   end

   // Next-state and counter logic.
   always_comb begin
      stateNext    = stateQ;
      stallCntNext = stallCntQ;
      drainCntNext = drainCntQ;

      if (brFlush) begin
         // Any pending halt was on the wrong path; drop it with the stall.
         stateNext    = RUN;
         stallCntNext = 4'd0;
         drainCntNext = 4'd0;
      end else begin
         case (stateQ)
            RUN: begin
               if (haz) begin
                  if (LD_STALL_CYCLES > 1) begin
                     stateNext    = LDSTALL;
                     stallCntNext = LdInit;
                  end
               end else if (bus.i_hlt) begin
                  stateNext    = DRAIN;
                  drainCntNext = DrainInit;
               end
            end
            LDSTALL: begin
               if (stallCntQ <= 4'd1) begin
                  stateNext    = RUN;
                  stallCntNext = 4'd0;
               end else begin
                  stallCntNext = stallCntQ - 4'd1;
               end
            end
            DRAIN: begin
               if (drainCntQ <= 4'd1) begin
                  stateNext    = HALTED;
                  drainCntNext = 4'd0;
               end else begin
                  drainCntNext = drainCntQ - 4'd1;
               end
            end
            HALTED: begin
               stateNext = HALTED;
            end
            default: begin
               stateNext    = RUN;
               stallCntNext = 4'd0;
               drainCntNext = 4'd0;
            end
         endcase
      end
   end

   // Pipeline control outputs, decoded from the current state and inputs.
   always_comb begin
      bus.o_stallPC    = 1'b0;
      bus.o_stallIFID  = 1'b0;
      bus.o_bubbleIDEX = 1'b0;
      bus.o_flushIFID  = 1'b0;
      bus.o_flushIDEX  = 1'b0;

      if (!i_rst) begin
         if (brFlush) begin
            bus.o_flushIFID = 1'b1;
            bus.o_flushIDEX = 1'b1;
         end else begin
            case (stateQ)
               RUN: begin
                  if (haz) begin
                     bus.o_stallPC    = 1'b1;
                     bus.o_stallIFID  = 1'b1;
                     bus.o_bubbleIDEX = 1'b1;
                  end else if (bus.i_hlt) begin
                     // Halt moves into EX untouched; fetch blocking starts in DRAIN.
                     bus.o_stallPC = 1'b0;
                  end else if (bus.i_jmp) begin
                     bus.o_flushIFID = 1'b1;
                  end
               end
               LDSTALL: begin
                  bus.o_stallPC    = 1'b1;
                  bus.o_stallIFID  = 1'b1;
                  bus.o_bubbleIDEX = 1'b1;
               end
               DRAIN, HALTED: begin
                  bus.o_stallPC   = 1'b1;
                  bus.o_flushIFID = 1'b1;
               end
               default: begin
                  bus.o_stallPC = 1'b0;
               end
            endcase
         end
      end
   end

   // Registered status outputs.
   always_comb begin
      bus.o_halted = haltedQ;
      bus.o_state  = stateQ;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with a 1-cycle load interlock,
// one with a 3-cycle interlock, both fed from the same stimulus.
module tb_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic [3:0] idRdReg1, idRdReg2, exWrReg;
   logic       idRdEn1, idRdEn2, exMemRd, exWrEn, brTaken, jmp, hlt;

   int nPass = 0;
   int nTot  = 0;

   hazard_ctrl_if ifA ();
   hazard_ctrl_if ifB ();

   hazard_ctrl #(.LD_STALL_CYCLES(1), .DRAIN_CYCLES(3)) dutA (.i_clk(clk), .i_rst(rst), .bus(ifA));
   hazard_ctrl #(.LD_STALL_CYCLES(3), .DRAIN_CYCLES(3)) dutB (.i_clk(clk), .i_rst(rst), .bus(ifB));

   assign ifA.i_idRdReg1 = idRdReg1;  assign ifB.i_idRdReg1 = idRdReg1;
   assign ifA.i_idRdEn1  = idRdEn1;   assign ifB.i_idRdEn1  = idRdEn1;
   assign ifA.i_idRdReg2 = idRdReg2;  assign ifB.i_idRdReg2 = idRdReg2;
   assign ifA.i_idRdEn2  = idRdEn2;   assign ifB.i_idRdEn2  = idRdEn2;
   assign ifA.i_exMemRd  = exMemRd;   assign ifB.i_exMemRd  = exMemRd;
   assign ifA.i_exWrReg  = exWrReg;   assign ifB.i_exWrReg  = exWrReg;
   assign ifA.i_exWrEn   = exWrEn;    assign ifB.i_exWrEn   = exWrEn;
   assign ifA.i_brTaken  = brTaken;   assign ifB.i_brTaken  = brTaken;
   assign ifA.i_jmp      = jmp;       assign ifB.i_jmp      = jmp;
   assign ifA.i_hlt      = hlt;       assign ifB.i_hlt      = hlt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      nTot++;
      assert (obs === exp) nPass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearIn();
      idRdReg1 = 4'd0; idRdReg2 = 4'd0; exWrReg = 4'd0;
      idRdEn1 = 1'b0; idRdEn2 = 1'b0; exMemRd = 1'b0; exWrEn = 1'b0;
      brTaken = 1'b0; jmp = 1'b0; hlt = 1'b0;
   endtask

   task automatic setLoadUse();
      exMemRd = 1'b1; exWrEn = 1'b1; exWrReg = 4'd3;
      idRdEn2 = 1'b1; idRdReg2 = 4'd3;
   endtask

   // Packs {stallPC, stallIFID, bubbleIDEX} and {flushIFID, flushIDEX}.
   function automatic logic [3:0] stA();
      return {1'b0, ifA.o_stallPC, ifA.o_stallIFID, ifA.o_bubbleIDEX};
   endfunction
   function automatic logic [3:0] stB();
      return {1'b0, ifB.o_stallPC, ifB.o_stallIFID, ifB.o_bubbleIDEX};
   endfunction
   function automatic logic [3:0] flA();
      return {2'b00, ifA.o_flushIFID, ifA.o_flushIDEX};
   endfunction
   function automatic logic [3:0] flB();
      return {2'b00, ifB.o_flushIFID, ifB.o_flushIDEX};
   endfunction

   initial begin
      clearIn();
      rst = 1'b1;
      setLoadUse();
      jmp = 1'b1;
      tick();
      tick();
      chk("rst_held_stall", stA(), 4'h0);
      chk("rst_held_flush", flA(), 4'h0);
      clearIn();
      rst = 1'b0;
      #1;
      chk("reset_state", 4'(ifA.o_state), 4'd0);
      chk("reset_halted", 4'(ifA.o_halted), 4'd0);

      // load-use on port 2
      setLoadUse();
      #1;
      chk("lu_A_c1", stA(), 4'h7);
      chk("lu_B_c1", stB(), 4'h7);
      chk("lu_flush", flA(), 4'h0);
      tick();
      clearIn();
      #1;
      chk("lu_A_after", stA(), 4'h0);
      chk("lu_B_state_c2", 4'(ifB.o_state), 4'd1);
      chk("lu_B_c2", stB(), 4'h7);
      tick();
      chk("lu_B_c3", stB(), 4'h7);
      tick();
      chk("lu_B_done_state", 4'(ifB.o_state), 4'd0);
      chk("lu_B_done", stB(), 4'h0);

      // r0 and disabled port never hazard; enabled port 1 does (comb only)
      exMemRd = 1'b1; exWrEn = 1'b1; exWrReg = 4'd0; idRdEn2 = 1'b1; idRdReg2 = 4'd0;
      #1;
      chk("zero_reg", stA(), 4'h0);
      clearIn();
      exMemRd = 1'b1; exWrEn = 1'b1; exWrReg = 4'd5; idRdEn1 = 1'b0; idRdReg1 = 4'd5;
      #1;
      chk("port_disabled", stA(), 4'h0);
      idRdEn1 = 1'b1;
      #1;
      chk("port1_match", stA(), 4'h7);
      exWrEn = 1'b0;
      #1;
      chk("no_write_en", stA(), 4'h0);
      clearIn();
      tick();

      // branch beats load-use
      setLoadUse();
      brTaken = 1'b1;
      #1;
      chk("br_haz_flush", flA(), 4'h3);
      chk("br_haz_stall", stA(), 4'h0);
      chk("br_haz_B_stall", stB(), 4'h0);
      tick();
      clearIn();
      chk("br_haz_state_A", 4'(ifA.o_state), 4'd0);
      chk("br_haz_state_B", 4'(ifB.o_state), 4'd0);

      // jump
      jmp = 1'b1;
      #1;
      chk("jmp_flush", flA(), 4'h2);
      tick();
      clearIn();
      #1;
      chk("jmp_after", flA(), 4'h0);

      // halt drain
      hlt = 1'b1;
      #1;
      chk("hlt_cycle_stall", stA(), 4'h0);
      chk("hlt_cycle_flush", flA(), 4'h0);
      tick();
      clearIn();
      for (int i = 0; i < 3; i++) begin
         chk("drain_state", 4'(ifA.o_state), 4'd2);
         chk("drain_stallpc", 4'(ifA.o_stallPC), 4'd1);
         chk("drain_flush", flA(), 4'h2);
         chk("drain_halted", 4'(ifA.o_halted), 4'd0);
         tick();
      end
      chk("halted_state", 4'(ifA.o_state), 4'd3);
      chk("halted_flag", 4'(ifA.o_halted), 4'd1);
      for (int i = 0; i < 10; i++) begin
         idRdReg1 = 4'($urandom_range(15)); idRdReg2 = 4'($urandom_range(15));
         exWrReg  = 4'($urandom_range(15));
         idRdEn1 = 1'($urandom_range(1)); idRdEn2 = 1'($urandom_range(1));
         exMemRd = 1'($urandom_range(1)); exWrEn = 1'($urandom_range(1));
         brTaken = 1'($urandom_range(1)); jmp = 1'($urandom_range(1));
         hlt = 1'($urandom_range(1));
         #1;
         chk("halted_hold_flag", 4'(ifA.o_halted), 4'd1);
         chk("halted_hold_state", 4'(ifA.o_state), 4'd3);
         chk("halted_hold_ctl", {ifA.o_stallPC, ifA.o_flushIFID, ifA.o_flushIDEX, ifA.o_bubbleIDEX}, 4'b1100);
         tick();
      end
      brTaken = 1'b1;
      #1;
      chk("halted_ignores_br", flA(), 4'h2);

      // reset while HALTED, then a jump
      rst = 1'b1;
      #1;
      chk("rst_halted_comb", stA(), 4'h0);
      chk("rst_halted_flush", flA(), 4'h0);
      tick();
      chk("rst_halted_state", 4'(ifA.o_state), 4'd0);
      chk("rst_halted_flag", 4'(ifA.o_halted), 4'd0);
      chk("rst_halted_held", {ifA.o_stallPC, ifA.o_flushIFID, ifA.o_flushIDEX, ifA.o_bubbleIDEX}, 4'h0);
      clearIn();
      rst = 1'b0;
      jmp = 1'b1;
      #1;
      chk("jmp_after_rst", flA(), 4'h2);
      tick();
      clearIn();
      #1;
      chk("jmp_after_rst_end", flA(), 4'h0);

      // branch on 2nd DRAIN cycle cancels the halt
      hlt = 1'b1;
      tick();
      clearIn();
      chk("cancel_drain1", 4'(ifA.o_state), 4'd2);
      tick();
      chk("cancel_drain2", 4'(ifA.o_state), 4'd2);
      brTaken = 1'b1;
      #1;
      chk("cancel_flush", flA(), 4'h3);
      chk("cancel_stall", stA(), 4'h0);
      tick();
      clearIn();
      for (int i = 0; i < 4; i++) begin
         chk("cancel_state", 4'(ifA.o_state), 4'd0);
         chk("cancel_halted", 4'(ifA.o_halted), 4'd0);
         tick();
      end

      // reset during LDSTALL (3-cycle instance)
      setLoadUse();
      tick();
      clearIn();
      chk("rst_ld_pre", 4'(ifB.o_state), 4'd1);
      rst = 1'b1;
      #1;
      chk("rst_ld_comb", stB(), 4'h0);
      chk("rst_ld_flush", flB(), 4'h0);
      tick();
      chk("rst_ld_state", 4'(ifB.o_state), 4'd0);
      chk("rst_ld_halted", 4'(ifB.o_halted), 4'd0);
      rst = 1'b0;
      #1;
      chk("rst_ld_after", stB(), 4'h0);

      $display("%0d/%0d checks passed", nPass, nTot);
      $finish;
   end

endmodule
